// File: rtl/aes_round_sequencer_if.sv
// Handshake bundle between the AES round sequencer and the datapath units.
// The sequencer sits on the slave side: it receives start/abort/done and
// drives the stage enables, the round number and the status flags.
interface aes_round_sequencer_if;
   logic       start;
   logic       abort;
   logic       key_done;
   logic       sb_done;
   logic       sr_done;
   logic       mc_done;
   logic       ark_done;
   logic       key_enable;
   logic       sb_enable;
   logic       sr_enable;
   logic       mc_enable;
   logic       ark_enable;
   logic [3:0] round_num;
   logic       busy;
   logic       done;

   modport master (
      output start, abort, key_done, sb_done, sr_done, mc_done, ark_done,
      input  key_enable, sb_enable, sr_enable, mc_enable, ark_enable,
      input  round_num, busy, done
   );

   modport slave (
      input  start, abort, key_done, sb_done, sr_done, mc_done, ark_done,
      output key_enable, sb_enable, sr_enable, mc_enable, ark_enable,
      output round_num, busy, done
   );
endinterface

// File: rtl/aes_round_sequencer.sv
// AES-128 round scheduler. After a start it runs the initial AddRoundKey and
// then, for rounds 1..NUM_ROUNDS, KeyExpansion, SubBytes, ShiftRows,
// MixColumns (skipped in the last round) and AddRoundKey. Each unit gets a
// one-cycle enable and the sequencer waits for its done before moving on.
// All outputs are registered copies of the next-state decode, so nothing
// combinational reaches the ports. NUM_ROUNDS must lie in 1..15.
module aes_round_sequencer #(
   parameter int NUM_ROUNDS = 10
) (
   input logic                  clk,
   input logic                  n_rst,
   aes_round_sequencer_if.slave bus
);

   typedef enum logic [3:0] {
      IDLE,
      ARK0_START,
      ARK0_WAIT,
      KEY_START,
      KEY_WAIT,
      SB_START,
      SB_WAIT,
      SR_START,
      SR_WAIT,
      MC_START,
      MC_WAIT,
      ARK_START,
      ARK_WAIT,
      DONE
   } state_t;

   localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

   state_t     state;
   state_t     nxt_state;
   logic [3:0] nxt_round;

   // Next-state and next-round decode; abort outranks every done input.
   always_comb begin
      nxt_state = state;
      nxt_round = bus.round_num;
      if (state != IDLE && bus.abort) begin
         nxt_state = IDLE;
         nxt_round = '0;
      end else begin
         case (state)
            IDLE: begin
               nxt_round = '0;
               if (bus.start) nxt_state = ARK0_START;
            end
            ARK0_START: nxt_state = ARK0_WAIT;
            ARK0_WAIT: begin
               if (bus.ark_done) begin
                  nxt_state = KEY_START;
                  nxt_round = 4'd1;
               end
            end
            KEY_START: nxt_state = KEY_WAIT;
            KEY_WAIT: begin
               if (bus.key_done) nxt_state = SB_START;
            end
            SB_START: nxt_state = SB_WAIT;
            SB_WAIT: begin
               if (bus.sb_done) nxt_state = SR_START;
            end
            SR_START: nxt_state = SR_WAIT;
            SR_WAIT: begin
               // The final round has no MixColumns.
               if (bus.sr_done) begin
                  nxt_state = (bus.round_num == LAST_ROUND) ? ARK_START : MC_START;
               end
            end
            MC_START: nxt_state = MC_WAIT;
            MC_WAIT: begin
               if (bus.mc_done) nxt_state = ARK_START;
            end
            ARK_START: nxt_state = ARK_WAIT;
            ARK_WAIT: begin
               if (bus.ark_done) begin
                  if (bus.round_num == LAST_ROUND) begin
                     nxt_state = DONE;
                  end else begin
                     nxt_state = KEY_START;
                     nxt_round = bus.round_num + 4'd1;
                  end
               end
            end
            DONE: begin
               nxt_state = IDLE;
               nxt_round = '0;
            end
            default: begin
               nxt_state = IDLE;
               nxt_round = '0;
            end
         endcase
      end
   end

   // State register plus registered Moore outputs decoded from the next state.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state          <= IDLE;
         bus.round_num  <= '0;
         bus.key_enable <= 1'b0;
         bus.sb_enable  <= 1'b0;
         bus.sr_enable  <= 1'b0;
         bus.mc_enable  <= 1'b0;
         bus.ark_enable <= 1'b0;
         bus.busy       <= 1'b0;
         bus.done       <= 1'b0;
      end else begin
         state          <= nxt_state;
         bus.round_num  <= nxt_round;
         bus.key_enable <= (nxt_state == KEY_START);
         bus.sb_enable  <= (nxt_state == SB_START);
         bus.sr_enable  <= (nxt_state == SR_START);
         bus.mc_enable  <= (nxt_state == MC_START);
         bus.ark_enable <= (nxt_state == ARK0_START) || (nxt_state == ARK_START);
         bus.busy       <= (nxt_state != IDLE) && (nxt_state != DONE);
         bus.done       <= (nxt_state == DONE);
      end
   end

endmodule

// File: doc/aes_round_sequencer.md
# aes_round_sequencer

Top-level round scheduler for the AES-128 encryption core. On a start pulse it walks `round_num` from 0 to NUM_ROUNDS and, for each round, fires one-cycle enables to the key expansion unit and to the SubBytes, ShiftRows, MixColumns and AddRoundKey stages in strict order. Each enable is followed by a wait for that unit's done. It owns the `roundNum` seen by key expansion and is the only block that tells the datapath when to move.

## Interface
- NUM_ROUNDS, 10, last round index; legal range 1..15; final round skips MixColumns.
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous, active-low reset.
- start  in  1  begin one block; sampled only in IDLE.
- abort  in  1  synchronous cancel; honoured in every non-IDLE state.
- key_done  in  1  key expansion finished (expansionDone).
- sb_done / sr_done / mc_done / ark_done  in  1 each  stage finished.
- key_enable  out  1  one-cycle pulse to key expansion.
- sb_enable / sr_enable / mc_enable / ark_enable  out  1 each  one-cycle stage pulses.
- round_num  out  4  current round; drives key expansion roundNum.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  one-cycle pulse: block complete.

## Operation
- States: IDLE, ARK0_START, ARK0_WAIT, KEY_START, KEY_WAIT, SB_START, SB_WAIT, SR_START, SR_WAIT, MC_START, MC_WAIT, ARK_START, ARK_WAIT, DONE.
- IDLE: round_num=0. start=1 -> ARK0_START. This is the initial AddRoundKey with the cipher key.
- Each X_START asserts exactly its own enable for one cycle, then always goes to X_WAIT.
- X_WAIT holds until its done is high at a rising edge, then advances:
  - ARK0_WAIT -> KEY_START, with round_num<=1.
  - KEY_WAIT -> SB_START.
  - SB_WAIT -> SR_START.
  - SR_WAIT -> MC_START if round_num!=NUM_ROUNDS, else ARK_START.
  - MC_WAIT -> ARK_START.
  - ARK_WAIT -> DONE if round_num==NUM_ROUNDS, else KEY_START with round_num<=round_num+1.
- DONE: done=1 for one cycle, then IDLE.
- Done inputs are ignored in every state except the matching WAIT. A done high during the START cycle, or a stray done from a different unit, has no effect.
- Enables are Moore outputs decoded from state only. At most one enable is high in any cycle.
- round_num is registered. It changes only on the transitions listed above, never exceeds NUM_ROUNDS and never wraps.
- abort=1 in any non-IDLE state, including DONE:
  - next state IDLE, round_num<=0;
  - no done pulse, no further enables;
  - abort beats any simultaneous done input.
- start while busy is ignored. start and abort together in IDLE: abort is irrelevant, and the sequence starts.
- Reset, asynchronous, any time including mid-round: state=IDLE, and all outputs (enables, busy, done, round_num) are 0.

## Timing
- Outputs are valid from the cycle after the state register updates. There are no combinational paths from inputs to outputs.
- Stage cost is 1 START cycle plus d WAIT cycles, where d≥1 is the number of cycles from the enable cycle to the cycle in which done is sampled high.
- With every unit returning done in the cycle right after its enable (d=1), for NUM_ROUNDS=10:
  - stage count is 1 + 9×5 + 4 = 50 stages, i.e. 100 cycles;
  - counting the ARK0_START cycle as cycle 1, done is high in cycle 101;
  - busy falls in the same cycle done rises.
- The earliest next start is sampled in the first IDLE cycle after DONE, giving 1 dead cycle between blocks.

## Test plan
- Nominal run: reset, start pulse, all dones echoed 1 cycle after enable, NUM_ROUNDS=10. Required:
  - ark_enable seen 11 times, key/sb/sr_enable 10 times each, mc_enable 9 times;
  - no mc_enable while round_num=10;
  - done exactly once, in cycle 101;
  - round_num sequence 0,1..10, then 0.
- Slow unit: key_done delayed 7 cycles in round 3. Required: the FSM holds KEY_WAIT with round_num=3 and no other enables, then resumes; total latency grows by exactly 6 cycles.
- Stray done: assert sb_done and ark_done during KEY_WAIT and during SB_START. Required: no state advance, no extra enables, round_num unchanged.
- Abort: assert abort in MC_WAIT of round 5, with mc_done also high that cycle. Required: next cycle IDLE, round_num=0, busy=0, no done. A fresh start afterwards runs a clean 101-cycle sequence.
- Reset mid-operation: drop n_rst during SR_START of round 8. Required: outputs 0 immediately, without waiting for a clock edge; sr_enable is not held after release.
- Start while busy, and NUM_ROUNDS=1: start pulses during round 2 are ignored. With NUM_ROUNDS=1 the sequence is ARK0, KEY, SB, SR, ARK, then done in cycle 11 with d=1.
